reg_read_arbiter: RTL and testbench



---
 rtl/reg_arb_pkg.sv | 19 +
 rtl/reg_read_arbiter_rr_picker.sv | 39 +++
 rtl/reg_read_arbiter.sv | 161 ++++++++++++++++
 tb/tb_reg_read_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register-file read-port arbiter.
package reg_arb_pkg;

  localparam int NREQ       = 4;
  localparam int DATA_W_DEF = 16;

  typedef logic [1:0] reg_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  function automatic logic [NREQ-1:0] idx_to_onehot(input reg_idx_t idx);
    idx_to_onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/reg_read_arbiter_rr_picker.sv
// Rotating-priority encoder: first eligible requester after the pointer wins.
module rr_picker
  import reg_arb_pkg::*;
(
  input  logic [NREQ-1:0] eligible,
  input  reg_idx_t        ptr,
  output logic [NREQ-1:0] winner_oh,
  output reg_idx_t        winner_idx,
  output logic            any_valid
);

  logic [NREQ-1:0] rot_s;
  reg_idx_t        offset_s;

  // Rotate the mask so bit 0 is the requester just after the pointer, then pick the lowest set bit.
  always_comb begin
    rot_s = {NREQ{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      rot_s[k] = eligible[reg_idx_t'(ptr + reg_idx_t'(k) + 2'd1)];
    end
    if (rot_s[0]) begin
      offset_s = 2'd0;
    end else if (rot_s[1]) begin
      offset_s = 2'd1;
    end else if (rot_s[2]) begin
      offset_s = 2'd2;
    end else begin
      offset_s = 2'd3;
    end
    any_valid  = |rot_s;
    winner_idx = ptr + offset_s + 2'd1;
    if (any_valid) begin
      winner_oh = idx_to_onehot(winner_idx);
    end else begin
      winner_oh = {NREQ{1'b0}};
    end
  end

endmodule

// File: rtl/reg_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port among four requesters.
// Optional burst lock with hold limit is enabled by defining REG_ARB_LOCK_EN.
module reg_read_arbiter
  import reg_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
`ifdef REG_ARB_LOCK_EN
  , parameter int MAX_HOLD = 4
`endif
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [NREQ-1:0]     Req,
  input  logic [2*NREQ-1:0]   ReqAddr,
`ifdef REG_ARB_LOCK_EN
  input  logic [NREQ-1:0]     Lock,
`endif
  input  logic [DATA_W-1:0]   THE_REG,
  output logic [1:0]          Select,
  output logic [NREQ-1:0]     Grant,
  output logic [DATA_W-1:0]   RdData,
  output logic [NREQ-1:0]     RdValid,
  output logic                Busy
);

  arb_state_e        state_r, state_s;
  reg_idx_t          ptr_r, gidx_r, select_r;
  logic [NREQ-1:0]   grant_r, rdvalid_r;
  logic [DATA_W-1:0] rddata_r;
  logic              busy_r;

  logic [NREQ-1:0]   eligible_s, pick_oh_s, win_oh_s;
  reg_idx_t          pick_idx_s, win_idx_s, win_addr_s;
  logic              pick_any_s, win_any_s, arb_en_s;

  // The requester just served still holds Req during DONE, so its RdValid masks it.
  assign eligible_s = Req & ~rdvalid_r;
  assign arb_en_s   = (state_r == IDLE) || (state_r == DONE);

  rr_picker u_picker (
    .eligible   (eligible_s),
    .ptr        (ptr_r),
    .winner_oh  (pick_oh_s),
    .winner_idx (pick_idx_s),
    .any_valid  (pick_any_s)
  );

`ifdef REG_ARB_LOCK_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_r;
  logic              lock_win_s;

  // A locked, still-requesting requester keeps the port until its hold budget runs out.
  always_comb begin
    lock_win_s = (state_r == DONE) && Lock[ptr_r] && Req[ptr_r] &&
                 (hold_r < HOLD_W'(MAX_HOLD));
    if (lock_win_s) begin
      win_oh_s  = idx_to_onehot(ptr_r);
      win_idx_s = ptr_r;
      win_any_s = 1'b1;
    end else begin
      win_oh_s  = pick_oh_s;
      win_idx_s = pick_idx_s;
      win_any_s = pick_any_s;
    end
  end

  // Count consecutive lock-extended grants; any rotation grant restarts the count at one.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_r <= {HOLD_W{1'b0}};
    end else if (arb_en_s && win_any_s) begin
      if (lock_win_s) begin
        hold_r <= hold_r + {{(HOLD_W-1){1'b0}}, 1'b1};
      end else begin
        hold_r <= {{(HOLD_W-1){1'b0}}, 1'b1};
      end
    end
  end
`else
  // Pure round-robin: the picker result is the winner.
  always_comb begin
    win_oh_s  = pick_oh_s;
    win_idx_s = pick_idx_s;
    win_any_s = pick_any_s;
  end
`endif

  assign win_addr_s = ReqAddr[{win_idx_s, 1'b0} +: 2];

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (win_any_s) state_s = READ;
        else           state_s = IDLE;
      end
      READ: state_s = DONE;
      DONE: begin
        if (win_any_s) state_s = READ;
        else           state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and registered busy flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
    end
  end

  // Grant/select launch on arbitration; data capture and pointer update at end of READ.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      grant_r   <= {NREQ{1'b0}};
      select_r  <= 2'd0;
      gidx_r    <= 2'd0;
      ptr_r     <= 2'd3;
      rddata_r  <= {DATA_W{1'b0}};
      rdvalid_r <= {NREQ{1'b0}};
    end else begin
      case (state_r)
        IDLE, DONE: begin
          rdvalid_r <= {NREQ{1'b0}};
          if (win_any_s) begin
            grant_r  <= win_oh_s;
            select_r <= win_addr_s;
            gidx_r   <= win_idx_s;
          end else begin
            grant_r  <= {NREQ{1'b0}};
          end
        end
        READ: begin
          rddata_r  <= THE_REG;
          rdvalid_r <= grant_r;
          grant_r   <= {NREQ{1'b0}};
          ptr_r     <= gidx_r;
        end
        default: begin
          grant_r   <= {NREQ{1'b0}};
          rdvalid_r <= {NREQ{1'b0}};
        end
      endcase
    end
  end

  assign Select  = select_r;
  assign Grant   = grant_r;
  assign RdData  = rddata_r;
  assign RdValid = rdvalid_r;
  assign Busy    = busy_r;

endmodule

// File: tb/tb_reg_read_arbiter.sv
// Scoreboard bench for reg_read_arbiter; lock scenario runs when REG_ARB_LOCK_EN is defined.
module tb_reg_read_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [3:0]  Req = 4'b0000;
  logic [7:0]  ReqAddr = 8'h00;
`ifdef REG_ARB_LOCK_EN
  logic [3:0]  Lock = 4'b0000;
`endif
  logic [15:0] THE_REG;
  logic [1:0]  Select;
  logic [3:0]  Grant;
  logic [15:0] RdData;
  logic [3:0]  RdValid;
  logic        Busy;

  int tests = 0;
  int fails = 0;

  typedef struct packed { logic [3:0] oh; logic [1:0] sel; } gexp_t;
  typedef struct packed { logic [3:0] oh; logic [15:0] data; } dexp_t;
  gexp_t gq[$];
  dexp_t dq[$];

  always #5 CLK = ~CLK;

  function automatic logic [15:0] reg_val(input logic [1:0] i);
    case (i)
      2'd0:    reg_val = 16'h1234;
      2'd1:    reg_val = 16'h5A5A;
      2'd2:    reg_val = 16'hBEEF;
      default: reg_val = 16'hC3C3;
    endcase
  endfunction

  assign THE_REG = reg_val(Select);

  reg_read_arbiter dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .Req     (Req),
    .ReqAddr (ReqAddr),
`ifdef REG_ARB_LOCK_EN
    .Lock    (Lock),
`endif
    .THE_REG (THE_REG),
    .Select  (Select),
    .Grant   (Grant),
    .RdData  (RdData),
    .RdValid (RdValid),
    .Busy    (Busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_read(input int r, input logic [1:0] a);
    gexp_t g;
    dexp_t d;
    g.oh = 4'b0001 << r;
    g.sel = a;
    d.oh = 4'b0001 << r;
    d.data = reg_val(a);
    gq.push_back(g);
    dq.push_back(d);
  endtask

  task automatic wait_valid(output int cyc, output logic [3:0] rv);
    cyc = 0;
    rv = 4'b0000;
    while (rv == 4'b0000 && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      rv = RdValid;
    end
    if (rv == 4'b0000) begin
      tests++;
      fails++;
      $display("FAIL wait_valid: no RdValid after %0d cycles", cyc);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents a grant or a read result.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (Grant != 4'b0000) begin
        if (gq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL grant_unexpected: got Grant=%b Select=%0d, none expected", Grant, Select);
        end else begin
          gexp_t g;
          g = gq.pop_front();
          check("grant", {28'd0, Grant}, {28'd0, g.oh});
          check("select", {30'd0, Select}, {30'd0, g.sel});
        end
      end
      if (RdValid != 4'b0000) begin
        if (dq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rdvalid_unexpected: got RdValid=%b RdData=%h, none expected", RdValid, RdData);
        end else begin
          dexp_t d;
          d = dq.pop_front();
          check("rdvalid", {28'd0, RdValid}, {28'd0, d.oh});
          check("rddata", {16'd0, RdData}, {16'd0, d.data});
        end
      end
    end
  end

  initial begin
    int cyc;
    logic [3:0] rv;

    repeat (2) @(negedge CLK);
    check("rst_grant", {28'd0, Grant}, 32'd0);
    check("rst_select", {30'd0, Select}, 32'd0);
    check("rst_rddata", {16'd0, RdData}, 32'd0);
    check("rst_rdvalid", {28'd0, RdValid}, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Single read: requester 0 reads reg2.
    @(negedge CLK);
    ReqAddr = 8'h02;
    Req = 4'b0001;
    expect_read(0, 2'd2);
    wait_valid(cyc, rv);
    check("t1_latency", cyc, 32'd2);
    Req = 4'b0000;
    repeat (2) @(negedge CLK);

    // All four requesting, each drops after its RdValid and re-raises.
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    ReqAddr = 8'hE4;
    Req = 4'b1111;
    for (int k = 0; k < 5; k++) expect_read(k % 4, 2'(k % 4));
    for (int k = 0; k < 5; k++) begin
      wait_valid(cyc, rv);
      check("t2_interval", cyc, (k == 0) ? 32'd2 : 32'd1);
      Req = Req & ~rv;
      if (k < 4) begin
        @(negedge CLK);
        Req = 4'b1111;
      end else begin
        Req = 4'b0000;
      end
    end
    repeat (2) @(negedge CLK);

    // Serve requester 1, then 1 and 2 together: 2 must win first.
    ReqAddr = 8'h0C;
    Req = 4'b0010;
    expect_read(1, 2'd3);
    wait_valid(cyc, rv);
    Req = 4'b0000;
    repeat (2) @(negedge CLK);
    Req = 4'b0110;
    expect_read(2, 2'd0);
    expect_read(1, 2'd3);
    wait_valid(cyc, rv);
    check("t3_first", {28'd0, rv}, 32'h4);
    Req = Req & ~rv;
    wait_valid(cyc, rv);
    check("t3_second", {28'd0, rv}, 32'h2);
    Req = 4'b0000;
    repeat (2) @(negedge CLK);

    // Req and ReqAddr change during READ: read still completes with the sampled address.
    ReqAddr = 8'h40;
    Req = 4'b1000;
    expect_read(3, 2'd1);
    @(negedge CLK);
    Req = 4'b0000;
    ReqAddr = 8'hC0;
    wait_valid(cyc, rv);
    check("t6_rv", {28'd0, rv}, 32'h8);
    @(negedge CLK);
    check("t6_busy", {31'd0, Busy}, 32'd0);
    check("t6_single_pulse", {28'd0, RdValid}, 32'd0);
    repeat (2) @(negedge CLK);

    // Async reset in the middle of READ.
    ReqAddr = 8'h30;
    Req = 4'b0100;
    begin
      gexp_t g;
      g.oh = 4'b0100;
      g.sel = 2'd3;
      gq.push_back(g);
    end
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check("t4_grant", {28'd0, Grant}, 32'd0);
    check("t4_select", {30'd0, Select}, 32'd0);
    check("t4_rdvalid", {28'd0, RdValid}, 32'd0);
    check("t4_busy", {31'd0, Busy}, 32'd0);
    Req = 4'b0101;
    ReqAddr = 8'h31;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    expect_read(0, 2'd1);
    expect_read(2, 2'd3);
    wait_valid(cyc, rv);
    check("t4_after_rst", {28'd0, rv}, 32'h1);
    Req = Req & ~rv;
    wait_valid(cyc, rv);
    Req = 4'b0000;
    repeat (2) @(negedge CLK);

`ifdef REG_ARB_LOCK_EN
    // Locked requester 0 gets four consecutive grants, then forced rotation to 1.
    ReqAddr = 8'h0E;
    Lock = 4'b0001;
    Req = 4'b0011;
    for (int k = 0; k < 4; k++) expect_read(0, 2'd2);
    expect_read(1, 2'd3);
    expect_read(0, 2'd2);
    for (int k = 0; k < 6; k++) begin
      wait_valid(cyc, rv);
      if (rv == 4'b0010) Req = Req & ~rv;
    end
    Req = 4'b0000;
    Lock = 4'b0000;
    repeat (2) @(negedge CLK);
`endif

    repeat (4) @(negedge CLK);
    check("grant_queue_drained", gq.size(), 32'd0);
    check("data_queue_drained", dq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
